rx_merge: RTL and testbench

//  Receive-side counterpart of the tx path: drains the two destination FIFOs (D0, D1)
//  by issuing POP_D0/POP_D1, merges their words into one receive FIFO, and hands them
//  to the consumer under a pop handshake. Per-destination word counters support
//  end-to-end checking of the tx/rx pair in the top-level bench.

---
 rtl/rx_merge.sv | 168 ++++++++++++++++
 tb/tb_rx_merge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_merge.sv
// Receive-side merger: drains destination FIFOs D0/D1 with round-robin pops into a
// local receive FIFO and hands words to the consumer under a pop handshake.
module rx_merge #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              init,
    input  logic [ADDR_W:0]   rx_fifo_high,
    input  logic              D0_EMPTY,
    input  logic              D1_EMPTY,
    input  logic [DATA_W-1:0] DATA_IN_D0,
    input  logic [DATA_W-1:0] DATA_IN_D1,
    output logic              POP_D0,
    output logic              POP_D1,
    input  logic              POP_RX,
    output logic [DATA_W-1:0] DATA_OUT_RX,
    output logic              VALID_OUT,
    output logic              RX_EMPTY,
    output logic              RX_FULL,
    output logic              IDLE,
    output logic              ERR,
    output logic [CNT_W-1:0]  CNT_D0,
    output logic [CNT_W-1:0]  CNT_D1
);
    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   thr_q, thr_d, occ_q, occ_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              inflight_q, inflight_d;
    logic              inflight_src_q, inflight_src_d;
    logic              rr_q, rr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d, err_q, err_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic              pop0, pop1, wr_en, rd_en, intake_ok, busy;
    logic [ADDR_W:0]   thr_clamped;
    logic [ADDR_W+1:0] credit_used;
    logic [DATA_W-1:0] wr_data;

    // Credit counts words already stored plus the one still in flight from a source,
    // so occupancy can never pass the threshold.
    always_comb begin
        thr_clamped = (rx_fifo_high > DEPTH_L) ? DEPTH_L : rx_fifo_high;
        credit_used = {1'b0, occ_q} + {{(ADDR_W+1){1'b0}}, inflight_q};
        intake_ok   = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) &&
                      (credit_used < {1'b0, thr_q});
        pop0 = 1'b0;
        pop1 = 1'b0;
        // rr_q=1 means D1 was served last, so D0 wins a tie.
        if (intake_ok) begin
            if (!D0_EMPTY && (D1_EMPTY || rr_q)) begin
                pop0 = 1'b1;
            end else if (!D1_EMPTY) begin
                pop1 = 1'b1;
            end
        end
        wr_en   = inflight_q;
        wr_data = inflight_src_q ? DATA_IN_D1 : DATA_IN_D0;
        rd_en   = POP_RX && (state_q != ST_RESET) && (occ_q != '0);
        busy    = !D0_EMPTY || !D1_EMPTY || (occ_q != '0) || inflight_q;
    end

    always_comb begin
        state_d        = state_q;
        thr_d          = thr_q;
        occ_d          = occ_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        inflight_d     = pop0 || pop1;
        inflight_src_d = pop1;
        rr_d           = pop1 ? 1'b1 : (pop0 ? 1'b0 : rr_q);
        data_out_d     = data_out_q;
        valid_d        = rd_en;
        err_d          = err_q || (POP_RX && (state_q != ST_RESET) && (occ_q == '0));
        cnt0_d         = cnt0_q;
        cnt1_d         = cnt1_q;

        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (init) thr_d = thr_clamped;
                else      state_d = ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (init) begin
                    state_d = ST_INIT;
                    thr_d   = thr_clamped;
                end else begin
                    state_d = busy ? ST_ACTIVE : ST_IDLE;
                end
            end
            default: state_d = ST_RESET;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (inflight_src_q) cnt1_d = cnt1_q + CNT_W'(1);
            else                cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            data_out_d = mem[rd_ptr_q];
        end
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + (ADDR_W+1)'(1);
            2'b01:   occ_d = occ_q - (ADDR_W+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q        <= ST_RESET;
            thr_q          <= DEPTH_L;
            occ_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_src_q <= 1'b0;
            rr_q           <= 1'b1;
            data_out_q     <= '0;
            valid_q        <= 1'b0;
            err_q          <= 1'b0;
            cnt0_q         <= '0;
            cnt1_q         <= '0;
        end else begin
            state_q        <= state_d;
            thr_q          <= thr_d;
            occ_q          <= occ_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            inflight_q     <= inflight_d;
            inflight_src_q <= inflight_src_d;
            rr_q           <= rr_d;
            data_out_q     <= data_out_d;
            valid_q        <= valid_d;
            err_q          <= err_d;
            cnt0_q         <= cnt0_d;
            cnt1_q         <= cnt1_d;
        end
    end

    // Storage carries no reset; inflight_q is cleared by reset so no stray write lands.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    assign POP_D0      = pop0;
    assign POP_D1      = pop1;
    assign DATA_OUT_RX = data_out_q;
    assign VALID_OUT   = valid_q;
    assign RX_EMPTY    = (occ_q == '0);
    assign RX_FULL     = (occ_q == DEPTH_L);
    assign IDLE        = (state_q == ST_IDLE);
    assign ERR         = err_q;
    assign CNT_D0      = cnt0_q;
    assign CNT_D1      = cnt1_q;
endmodule

// File: tb/tb_rx_merge.sv
// Scoreboard bench for rx_merge: source FIFO models feed D0/D1, expected words are
// queued at stimulus time and a monitor compares every VALID_OUT word.
module tb_rx_merge;
    localparam int DATA_W = 6;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              RESET_L, init, D0_EMPTY, D1_EMPTY, POP_D0, POP_D1, POP_RX;
    logic [ADDR_W:0]   rx_fifo_high;
    logic [DATA_W-1:0] DATA_IN_D0, DATA_IN_D1, DATA_OUT_RX;
    logic              VALID_OUT, RX_EMPTY, RX_FULL, IDLE, ERR;
    logic [CNT_W-1:0]  CNT_D0, CNT_D1;

    always #5 clk = ~clk;

    rx_merge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .RESET_L(RESET_L), .init(init), .rx_fifo_high(rx_fifo_high),
        .D0_EMPTY(D0_EMPTY), .D1_EMPTY(D1_EMPTY),
        .DATA_IN_D0(DATA_IN_D0), .DATA_IN_D1(DATA_IN_D1),
        .POP_D0(POP_D0), .POP_D1(POP_D1), .POP_RX(POP_RX),
        .DATA_OUT_RX(DATA_OUT_RX), .VALID_OUT(VALID_OUT), .RX_EMPTY(RX_EMPTY),
        .RX_FULL(RX_FULL), .IDLE(IDLE), .ERR(ERR), .CNT_D0(CNT_D0), .CNT_D1(CNT_D1)
    );

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int valid_base = 0;
    logic [DATA_W-1:0] src0[$], src1[$], sb_q[$];
    logic [DATA_W-1:0] sb_exp;
    int pop_src[$];
    int pop_cyc[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int count_src(input int s);
        int n = 0;
        foreach (pop_src[i]) if (pop_src[i] == s) n++;
        return n;
    endfunction

    // Source FIFO model: a pop seen before edge N presents its word just after edge N.
    initial begin
        logic p0, p1;
        D0_EMPTY = 1'b1;
        D1_EMPTY = 1'b1;
        DATA_IN_D0 = '0;
        DATA_IN_D1 = '0;
        forever begin
            @(negedge clk);
            p0 = POP_D0;
            p1 = POP_D1;
            @(posedge clk);
            #1;
            if (p0 && src0.size() > 0) DATA_IN_D0 = src0.pop_front();
            if (p1 && src1.size() > 0) DATA_IN_D1 = src1.pop_front();
            D0_EMPTY = (src0.size() == 0);
            D1_EMPTY = (src1.size() == 0);
        end
    end

    // Monitor: logs source pops and checks each delivered word against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (RESET_L) begin
            if (POP_D0 || POP_D1) begin
                check("pop_onehot", int'(POP_D0) + int'(POP_D1), 1);
                pop_src.push_back(POP_D1 ? 1 : 0);
                pop_cyc.push_back(cyc);
            end
            if (VALID_OUT) begin
                valid_cnt++;
                if (sb_q.size() == 0) begin
                    check("rx_unexpected_word", int'(DATA_OUT_RX), -1);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check("rx_data", int'(DATA_OUT_RX), int'(sb_exp));
                    $display("rx word %02h (expected %02h) at cycle %0d", DATA_OUT_RX, sb_exp, cyc);
                end
            end
        end
    end

    task automatic clear_logs();
        pop_src.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset_init(input int thr);
        @(negedge clk);
        RESET_L = 1'b0;
        init    = 1'b0;
        POP_RX  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_empty", int'(RX_EMPTY), 1);
        check("rst_valid", int'(VALID_OUT), 0);
        check("rst_err", int'(ERR), 0);
        check("rst_cnt_d0", int'(CNT_D0), 0);
        check("rst_idle", int'(IDLE), 0);
        check("rst_data_out", int'(DATA_OUT_RX), 0);
        RESET_L      = 1'b1;
        init         = 1'b1;
        rx_fifo_high = (ADDR_W+1)'(thr);
        repeat (3) @(negedge clk);
        init = 1'b0;
        repeat (2) @(negedge clk);
        check("init_to_idle", int'(IDLE), 1);
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        RESET_L = 1'b0; init = 1'b0; POP_RX = 1'b0; rx_fifo_high = '0;

        // Test 1: three words from D0 only
        do_reset_init(8);
        for (int i = 1; i <= 3; i++) begin
            src0.push_back(DATA_W'(i));
            sb_q.push_back(DATA_W'(i));
        end
        repeat (10) @(negedge clk);
        check("t1_pops", pop_src.size(), 3);
        check("t1_pops_from_d1", count_src(1), 0);
        if (pop_cyc.size() == 3) check("t1_consecutive", pop_cyc[2] - pop_cyc[0], 2);
        check("t1_cnt_d0", int'(CNT_D0), 3);
        check("t1_idle_dropped", int'(IDLE), 0);
        check("t1_not_empty", int'(RX_EMPTY), 0);
        POP_RX = 1'b1;
        repeat (3) @(negedge clk);
        POP_RX = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_idle_back", int'(IDLE), 1);
        check("t1_empty", int'(RX_EMPTY), 1);
        check("t1_sb_drained", sb_q.size(), 0);
        check("t1_err", int'(ERR), 0);

        // Test 2: both sources, alternating service starting with D0
        do_reset_init(8);
        for (int i = 0; i < 4; i++) begin
            src0.push_back(DATA_W'(8'h10 + i));
            src1.push_back(DATA_W'(8'h20 + i));
            sb_q.push_back(DATA_W'(8'h10 + i));
            sb_q.push_back(DATA_W'(8'h20 + i));
        end
        repeat (14) @(negedge clk);
        check("t2_pops", pop_src.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < pop_src.size()) check("t2_pop_order", pop_src[i], i % 2);
        check("t2_full", int'(RX_FULL), 1);
        POP_RX = 1'b1;
        repeat (8) @(negedge clk);
        POP_RX = 1'b0;
        repeat (3) @(negedge clk);
        check("t2_empty", int'(RX_EMPTY), 1);
        check("t2_cnt_d0", int'(CNT_D0), 4);
        check("t2_cnt_d1", int'(CNT_D1), 4);
        check("t2_sb_drained", sb_q.size(), 0);

        // Test 3: threshold 4 limits intake; one read frees exactly one credit
        do_reset_init(4);
        for (int i = 0; i < 10; i++) begin
            src0.push_back(DATA_W'(8'h30 + i));
            sb_q.push_back(DATA_W'(8'h30 + i));
        end
        repeat (15) @(negedge clk);
        check("t3_pops_at_thr", pop_src.size(), 4);
        check("t3_not_full", int'(RX_FULL), 0);
        POP_RX = 1'b1;
        @(negedge clk);
        POP_RX = 1'b0;
        repeat (6) @(negedge clk);
        check("t3_one_more_pop", pop_src.size(), 5);

        // Raise threshold to 8 mid-stream; FIFO contents are kept and it fills up
        init = 1'b1;
        rx_fifo_high = 4'd8;
        repeat (2) @(negedge clk);
        init = 1'b0;
        repeat (15) @(negedge clk);
        check("t3_full_after_thr8", int'(RX_FULL), 1);
        check("t3_pops_after_thr8", pop_src.size(), 9);

        // Test 4: full FIFO with POP_RX held streams one word per cycle
        for (int i = 0; i < 20; i++) begin
            src0.push_back(DATA_W'(i));
            sb_q.push_back(DATA_W'(i));
        end
        valid_base = valid_cnt;
        POP_RX = 1'b1;
        repeat (29) @(negedge clk);
        POP_RX = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_valid_words", valid_cnt - valid_base, 29);
        check("t4_err", int'(ERR), 0);
        check("t4_empty", int'(RX_EMPTY), 1);
        check("t4_sb_drained", sb_q.size(), 0);
        check("t4_cnt_d0", int'(CNT_D0), 30);
        check("t4_total_pops", pop_src.size(), 30);

        // Test 5: read on empty FIFO sets a sticky error
        valid_base = valid_cnt;
        POP_RX = 1'b1;
        @(negedge clk);
        POP_RX = 1'b0;
        check("t5_err_set", int'(ERR), 1);
        check("t5_no_valid", int'(VALID_OUT), 0);
        repeat (5) @(negedge clk);
        check("t5_err_sticky", int'(ERR), 1);
        check("t5_no_words", valid_cnt - valid_base, 0);

        // Test 6: asynchronous reset during a pop burst
        clear_logs();
        for (int i = 0; i < 6; i++) src0.push_back(DATA_W'(8'h05 + i));
        repeat (3) @(negedge clk);
        check("t6_pop_in_flight", int'(POP_D0), 1);
        RESET_L = 1'b0;
        #1;
        check("t6_rst_pop_d0", int'(POP_D0), 0);
        check("t6_rst_valid", int'(VALID_OUT), 0);
        check("t6_rst_empty", int'(RX_EMPTY), 1);
        check("t6_rst_err", int'(ERR), 0);
        check("t6_rst_cnt_d0", int'(CNT_D0), 0);
        check("t6_rst_idle", int'(IDLE), 0);
        src0.delete();
        sb_q.delete();
        repeat (3) @(negedge clk);
        do_reset_init(8);
        repeat (4) @(negedge clk);
        check("t6_cnt_d0_after", int'(CNT_D0), 0);
        check("t6_empty_after", int'(RX_EMPTY), 1);
        check("t6_no_pops_after", pop_src.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
